id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
Pipeline sequencing controller for the ID stage. It detects RAW hazards between the decoded source registers and the destinations in EX and MEM, and drives the forwarding selects for RD1/RD2. It also generates stall and flush controls for load-use interlocks, taken-branch bubbles and syscall-exit halt, and keeps saturating performance counters. It sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline registers.

Parameters:
BRANCH_BUBBLES, 2, number of consecutive cycles flush_ifid is asserted after a taken branch (legal range 1..7)
HALT_CODE, 10, $v0 value that makes a syscall terminate execution
CNT_W, 16, width of the stall and bubble counters

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
id_rs  input  5  first source register number in ID (already muxed to 4 for syscall)
id_rt  input  5  second source register number in ID (already muxed to 2 for syscall)
id_use_rs  input  1  ID instruction reads id_rs
id_use_rt  input  1  ID instruction reads id_rt
id_syscall  input  1  ID instruction is syscall
id_v0  input  32  forwarded RD2 value seen by the syscall ($v0)
ex_wreg  input  5  destination register in EX
ex_regwrite  input  1  EX instruction writes the register file
ex_memread  input  1  EX instruction is a load
mem_wreg  input  5  destination register in MEM
mem_regwrite  input  1  MEM instruction writes the register file
branch_taken  input  1  EX resolved a taken branch or jump
fwd_a  output  2  RD1 select: 00 regfile, 01 EX result, 10 MEM result
fwd_b  output  2  RD2 select, same encoding
stall_pc  output  1  hold PC
stall_ifid  output  1  hold IF/ID
flush_idex  output  1  insert a bubble into ID/EX
flush_ifid  output  1  squash IF/ID
halted  output  1  processor halted
stall_cnt  output  CNT_W  cycles stalled by interlock
bubble_cnt  output  CNT_W  cycles with flush_ifid asserted

Behaviour:
- Reset (asynchronous): state=RUN, flush count=0, stall_cnt=0, bubble_cnt=0, halted=0. All stall and flush outputs are 0 while rst is high.
- Forwarding (combinational, active in every state):
  - exm_a = ex_regwrite & !ex_memread & ex_wreg!=0 & ex_wreg==id_rs
  - memm_a = mem_regwrite & mem_wreg!=0 & mem_wreg==id_rs
  - fwd_a = exm_a ? 01 : memm_a ? 10 : 00. EX has priority over MEM.
  - fwd_b uses the same rules with id_rt.
  - Register 0 is never forwarded and never causes a stall.
- load_use = ex_memread & ex_regwrite & ex_wreg!=0 & ((id_use_rs & ex_wreg==id_rs) | (id_use_rt & ex_wreg==id_rt)).
- sys_wait = id_syscall & ex_regwrite & ex_wreg==2 & ex_memread. A syscall waits out a load of $v0; ALU results reach it through forwarding.
- halt_req = id_syscall & !sys_wait & id_v0==HALT_CODE.
- FSM states: RUN, FLUSH, HALT. Outputs are combinational from state and inputs. Priority within RUN is branch > halt > interlock.
- RUN:
  - If branch_taken: flush_ifid=1, flush_idex=1, no stall. Load cnt=BRANCH_BUBBLES-1. Go to FLUSH if cnt>0, else stay in RUN.
  - Else if halt_req: stall_pc=stall_ifid=flush_idex=1. Go to HALT; halted=1 from the next cycle.
  - Else if load_use|sys_wait: stall_pc=stall_ifid=flush_idex=1 for this cycle; stall_cnt++. Stay in RUN. The stall releases naturally once the load leaves EX, so a load-use costs exactly 1 cycle.
  - Else all controls are 0.
- FLUSH: flush_ifid=1; cnt--; return to RUN when cnt reaches 0. Hazards and branch_taken are ignored because the ID contents are squashed.
- HALT: stall_pc=stall_ifid=flush_idex=1, halted=1. Exit only by rst. Counters freeze.
- Counters: bubble_cnt increments every cycle flush_ifid=1. Both counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-FLUSH or mid-HALT returns to RUN immediately with counters cleared.

Test Plan:
- EX add writes r5, ID reads rs=5 and MEM also writes r5 -> fwd_a=01, no stall. Same with ex_regwrite=0 -> fwd_a=10.
- EX lw r8, ID uses rt=8 -> exactly 1 cycle of stall_pc=stall_ifid=flush_idex=1, stall_cnt 0->1, then fwd_b=10 on the next cycle.
- branch_taken pulse with BRANCH_BUBBLES=2 -> flush_ifid high for 2 cycles, flush_idex for 1, bubble_cnt=2. A concurrent load_use gives stall_cnt unchanged.
- Syscall with id_v0=10 and no hazard -> halted=1 the next cycle and stays high for 20 cycles with all stalls high. id_v0=1 -> no halt.
- Syscall while EX lw writes r2 -> 1 stall cycle, then halt evaluated on the updated id_v0.
- Assert rst during FLUSH and during HALT -> all outputs 0 immediately, counters 0. ex_wreg=0 matches never forward or stall.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// Purpose: ID-stage sequencing: RAW forwarding selects, load-use/syscall interlock, branch bubbles, halt.
// Latency: forwarding and stall/flush controls are combinational in the current cycle; halted follows one cycle after the halting syscall.
// Backpressure: stalls PC and IF/ID for one cycle per interlock; HALT holds the front end until reset.
module id_hazard_ctrl #(
    parameter int          BRANCH_BUBBLES = 2,
    parameter logic [31:0] HALT_CODE      = 32'd10,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_syscall,
    input  logic [31:0]      id_v0,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       mem_wreg,
    input  logic             mem_regwrite,
    input  logic             branch_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_idex,
    output logic             flush_ifid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Bubbles still owed after the first one, which is issued in RUN itself.
    localparam logic [2:0]       BUB_INIT = 3'(BRANCH_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t     state;
    logic [2:0] cnt;

    logic exm_a, memm_a, exm_b, memm_b;
    logic load_use, sys_wait, halt_req;
    logic interlock;

    // Hazard detection against the EX and MEM destinations; r0 never matches.
    always_comb begin
        exm_a    = ex_regwrite & ~ex_memread & (ex_wreg != 5'd0) & (ex_wreg == id_rs);
        memm_a   = mem_regwrite & (mem_wreg != 5'd0) & (mem_wreg == id_rs);
        exm_b    = ex_regwrite & ~ex_memread & (ex_wreg != 5'd0) & (ex_wreg == id_rt);
        memm_b   = mem_regwrite & (mem_wreg != 5'd0) & (mem_wreg == id_rt);
        load_use = ex_memread & ex_regwrite & (ex_wreg != 5'd0) &
                   ((id_use_rs & (ex_wreg == id_rs)) | (id_use_rt & (ex_wreg == id_rt)));
        // A load of $v0 is not forwardable yet, so the syscall must wait it out.
        sys_wait = id_syscall & ex_regwrite & ex_memread & (ex_wreg == 5'd2);
        halt_req = id_syscall & ~sys_wait & (id_v0 == HALT_CODE);
    end

    // Forwarding selects; the younger EX result wins over MEM.
    always_comb begin
        fwd_a = exm_a ? 2'b01 : (memm_a ? 2'b10 : 2'b00);
        fwd_b = exm_b ? 2'b01 : (memm_b ? 2'b10 : 2'b00);
    end

    // Stall/flush controls from state and inputs; forced quiet while reset is held.
    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush_idex = 1'b0;
        flush_ifid = 1'b0;
        interlock  = 1'b0;
        halted     = (state == HALT);
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (halt_req) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (load_use | sys_wait) begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                        interlock  = 1'b1;
                    end
                end
                FLUSH: begin
                    flush_ifid = 1'b1;
                end
                HALT: begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
                default: begin
                    flush_ifid = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, bubble countdown and saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= 3'd0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (interlock && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_ifid && (bubble_cnt != CNT_MAX)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        cnt <= BUB_INIT;
                        if (BUB_INIT != 3'd0) begin
                            state <= FLUSH;
                        end
                    end else if (halt_req) begin
                        state <= HALT;
                    end
                end
                FLUSH: begin
                    cnt <= cnt - 3'd1;
                    if (cnt <= 3'd1) begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        sys;
        logic [31:0] v0;
        logic [4:0]  exw;
        logic        exrw;
        logic        exmr;
        logic [4:0]  memw;
        logic        memrw;
        logic        br;
    } stim_t;

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          spc;
        logic          sif;
        logic          fidex;
        logic          fifid;
        logic          hlt;
        logic [CW-1:0] sc;
        logic [CW-1:0] bc;
    } out_t;

    logic          clk;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_wreg, mem_wreg;
    logic          id_use_rs, id_use_rt, id_syscall;
    logic [31:0]   id_v0;
    logic          ex_regwrite, ex_memread, mem_regwrite, branch_taken;
    logic [1:0]    fwd_a, fwd_b;
    logic          stall_pc, stall_ifid, flush_idex, flush_ifid, halted;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    int   checks   = 0;
    int   failures = 0;
    out_t exp_q[$];

    id_hazard_ctrl #(
        .BRANCH_BUBBLES(2),
        .HALT_CODE(32'd10),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt),
        .id_syscall(id_syscall),
        .id_v0(id_v0),
        .ex_wreg(ex_wreg),
        .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread),
        .mem_wreg(mem_wreg),
        .mem_regwrite(mem_regwrite),
        .branch_taken(branch_taken),
        .fwd_a(fwd_a),
        .fwd_b(fwd_b),
        .stall_pc(stall_pc),
        .stall_ifid(stall_ifid),
        .flush_idex(flush_idex),
        .flush_ifid(flush_ifid),
        .halted(halted),
        .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(int r, int rs, int rt, int urs, int urt, int sys, int v0,
                                 int exw, int exrw, int exmr, int memw, int memrw, int br);
        stim_t s;
        s.rst   = 1'(r);
        s.rs    = 5'(rs);
        s.rt    = 5'(rt);
        s.urs   = 1'(urs);
        s.urt   = 1'(urt);
        s.sys   = 1'(sys);
        s.v0    = 32'(v0);
        s.exw   = 5'(exw);
        s.exrw  = 1'(exrw);
        s.exmr  = 1'(exmr);
        s.memw  = 5'(memw);
        s.memrw = 1'(memrw);
        s.br    = 1'(br);
        return s;
    endfunction

    function automatic stim_t idle(int r);
        return mk(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // st drives both stall_pc and stall_ifid expectations.
    function automatic out_t ex(int fa, int fb, int st, int fx, int fi, int hl, int sc, int bc);
        out_t o;
        o.fa    = 2'(fa);
        o.fb    = 2'(fb);
        o.spc   = 1'(st);
        o.sif   = 1'(st);
        o.fidex = 1'(fx);
        o.fifid = 1'(fi);
        o.hlt   = 1'(hl);
        o.sc    = CW'(sc);
        o.bc    = CW'(bc);
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.fa    = fwd_a;
        o.fb    = fwd_b;
        o.spc   = stall_pc;
        o.sif   = stall_ifid;
        o.fidex = flush_idex;
        o.fifid = flush_ifid;
        o.hlt   = halted;
        o.sc    = stall_cnt;
        o.bc    = bubble_cnt;
        return o;
    endfunction

    // Apply one stimulus vector just after a rising edge and queue what it should produce.
    task automatic drive(input stim_t s, input out_t e);
        @(posedge clk);
        #1;
        rst          = s.rst;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_use_rs    = s.urs;
        id_use_rt    = s.urt;
        id_syscall   = s.sys;
        id_v0        = s.v0;
        ex_wreg      = s.exw;
        ex_regwrite  = s.exrw;
        ex_memread   = s.exmr;
        mem_wreg     = s.memw;
        mem_regwrite = s.memrw;
        branch_taken = s.br;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        // Reset held while every control-raising input is active.
        s.push_back(mk(1, 0, 8, 0, 1, 1, 10, 8, 1, 1, 0, 0, 1)); e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(idle(1));                                      e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(idle(0));                                      e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset step %0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_forward();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(idle(1));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 5, 0, 1, 0, 0, 0, 5, 1, 0, 5, 1, 0));   e.push_back(ex(1, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 5, 0, 1, 0, 0, 0, 5, 0, 0, 5, 1, 0));   e.push_back(ex(2, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 5, 7, 1, 1, 0, 0, 5, 1, 0, 7, 1, 0));   e.push_back(ex(1, 2, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 7, 5, 1, 1, 0, 0, 5, 1, 0, 7, 1, 0));   e.push_back(ex(2, 1, 0, 0, 0, 0, 0, 0));
        // r0 destinations never forward, and a load into r0 never stalls.
        s.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0));   e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0));   e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        // A load in EX is not a forwarding source; unused operands do not stall.
        s.push_back(mk(0, 9, 9, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0));   e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0));   e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL forward step %0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(idle(1));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0));   e.push_back(ex(0, 0, 1, 1, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 8, 0, 1, 0, 0, 0, 0, 0, 8, 1, 0));   e.push_back(ex(0, 2, 0, 0, 0, 0, 1, 0));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 1, 0));
        s.push_back(mk(0, 6, 0, 1, 0, 0, 0, 6, 1, 1, 0, 0, 0));   e.push_back(ex(0, 0, 1, 1, 0, 0, 1, 0));
        s.push_back(mk(0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 6, 1, 0));   e.push_back(ex(2, 0, 0, 0, 0, 0, 2, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL load_use step %0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_branch();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(idle(1));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        // Branch wins over a concurrent load-use; the FLUSH cycle ignores both.
        s.push_back(mk(0, 0, 8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 1));   e.push_back(ex(0, 0, 0, 1, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 1));   e.push_back(ex(0, 0, 0, 0, 1, 0, 0, 1));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 2));
        // Back-to-back branches once RUN is re-entered.
        s.push_back(idle(0) | mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); e.push_back(ex(0, 0, 0, 1, 1, 0, 0, 2));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 0, 0, 1, 0, 0, 3));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));   e.push_back(ex(0, 0, 0, 1, 1, 0, 0, 4));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 0, 0, 1, 0, 0, 5));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 6));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL branch step %0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_halt();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(idle(1));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 4, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));   e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 4, 2, 1, 1, 1, 10, 0, 0, 0, 0, 0, 0));  e.push_back(ex(0, 0, 1, 1, 0, 0, 0, 0));
        // Once halted, branches and load-use hazards change nothing and counters hold.
        for (int k = 0; k < 20; k++) begin
            s.push_back(mk(0, 0, 8, 0, 1, 0, 0, 8, 1, 1, 0, 0, k % 2));
            e.push_back(ex(0, 0, 1, 1, 0, 1, 0, 0));
        end
        foreach (s[i]) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL halt step %0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_sys_wait();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(idle(1));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        // Stale $v0 already equals the halt code, but the pending load must be waited out.
        s.push_back(mk(0, 4, 2, 0, 0, 1, 10, 2, 1, 1, 0, 0, 0));  e.push_back(ex(0, 0, 1, 1, 0, 0, 0, 0));
        s.push_back(mk(0, 4, 2, 0, 0, 1, 10, 0, 0, 0, 2, 1, 0));  e.push_back(ex(0, 2, 1, 1, 0, 0, 1, 0));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 1, 1, 0, 1, 1, 0));
        // $v0 produced by an ALU op in EX is forwarded, so no wait.
        s.push_back(idle(1));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 4, 2, 0, 0, 1, 1, 2, 1, 1, 0, 0, 0));   e.push_back(ex(0, 0, 1, 1, 0, 0, 0, 0));
        s.push_back(mk(0, 4, 2, 0, 0, 1, 1, 0, 0, 0, 2, 1, 0));   e.push_back(ex(0, 2, 0, 0, 0, 0, 1, 0));
        s.push_back(mk(0, 4, 2, 0, 0, 1, 10, 2, 1, 0, 0, 0, 0));  e.push_back(ex(0, 1, 1, 1, 0, 0, 1, 0));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 1, 1, 0, 1, 1, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL sys_wait step %0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(idle(1));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));   e.push_back(ex(0, 0, 0, 1, 1, 0, 0, 0));
        // Reset lands in FLUSH with branch still asserted.
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));   e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 4, 2, 1, 1, 1, 10, 0, 0, 0, 0, 0, 0));  e.push_back(ex(0, 0, 1, 1, 0, 0, 0, 0));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 1, 1, 0, 1, 0, 0));
        s.push_back(idle(1));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(idle(0));                                     e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid step %0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_saturate();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        int    cmax;
        cmax = (1 << CW) - 1;
        s.push_back(idle(1)); e.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 18; k++) begin
            s.push_back(mk(0, 0, 8, 0, 1, 0, 0, 8, 1, 1, 0, 0, 0));
            e.push_back(ex(0, 0, 1, 1, 0, 0, (k < cmax) ? k : cmax, 0));
        end
        for (int r = 0; r < 9; r++) begin
            s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            e.push_back(ex(0, 0, 0, 1, 1, 0, cmax, (2 * r < cmax) ? 2 * r : cmax));
            s.push_back(idle(0));
            e.push_back(ex(0, 0, 0, 0, 1, 0, cmax, (2 * r + 1 < cmax) ? 2 * r + 1 : cmax));
        end
        s.push_back(idle(0)); e.push_back(ex(0, 0, 0, 0, 0, 0, cmax, cmax));
        foreach (s[i]) begin
            drive(s[i], e[i]);
            @(negedge clk);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL saturate step %0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        id_rs        = '0;
        id_rt        = '0;
        id_use_rs    = 1'b0;
        id_use_rt    = 1'b0;
        id_syscall   = 1'b0;
        id_v0        = '0;
        ex_wreg      = '0;
        ex_regwrite  = 1'b0;
        ex_memread   = 1'b0;
        mem_wreg     = '0;
        mem_regwrite = 1'b0;
        branch_taken = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_halt();
        test_sys_wait();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
